// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: streams prog_len words from program memory into a
// DEPTH-entry queue, two per cycle. Optional stall counter via IFQ_STALL_CNT_EN.
module instruction_fetch_queue #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 8,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     prog_we,
    input  logic [PC_W-1:0]          prog_addr,
    input  logic [INST_W-1:0]        prog_data,
    input  logic [PC_W-1:0]          prog_len,
    input  logic                     start,
    input  logic [1:0]               issue_take,
    output logic [INST_W-1:0]        inst0,
    output logic                     inst0_valid,
    output logic [INST_W-1:0]        inst1,
    output logic                     inst1_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fetch_done,
    output logic [15:0]              cycle_count
`ifdef IFQ_STALL_CNT_EN
    ,
    output logic [15:0]              stall_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t              state;
    logic [INST_W-1:0]   prog_mem  [2**PC_W];
    logic [INST_W-1:0]   queue_mem [DEPTH];
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [PC_W-1:0]     fetch_pc;
    logic [PC_W-1:0]     len;

    logic [CW-1:0]       free_slots;
    logic [PC_W-1:0]     remaining;
    logic [1:0]          fill_n;
    logic [1:0]          take_req;
    logic [CW-1:0]       take_eff;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        free_slots = CW'(DEPTH) - count;
        remaining  = len - fetch_pc;
        fill_n     = 2'd0;
        if (state == FETCH) begin
            if (free_slots >= CW'(2) && remaining >= PC_W'(2))
                fill_n = 2'd2;
            else if (free_slots != '0 && remaining != '0)
                fill_n = 2'd1;
        end
        take_req = (issue_take == 2'd3) ? 2'd2 : issue_take;
        take_eff = (CW'(take_req) > count) ? count : CW'(take_req);
    end

    // NOTE: storage arrays are deliberately not reset; count gates every read of the queue.
    always_ff @(posedge clk) begin
        if (prog_we)
            prog_mem[prog_addr] <= prog_data;
        if (fill_n != 2'd0)
            queue_mem[tail] <= prog_mem[fetch_pc];
        if (fill_n == 2'd2)
            queue_mem[tail + PW'(1)] <= prog_mem[fetch_pc + PC_W'(1)];
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            fetch_pc    <= '0;
            len         <= '0;
            cycle_count <= '0;
            fetch_done  <= 1'b0;
        end else if (start) begin
            state       <= FETCH;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            fetch_pc    <= '0;
            len         <= prog_len;
            cycle_count <= '0;
            fetch_done  <= 1'b0;
        end else begin
            count    <= count + CW'(fill_n) - take_eff;
            head     <= head + take_eff[PW-1:0];
            tail     <= tail + PW'(fill_n);
            fetch_pc <= fetch_pc + PC_W'(fill_n);
            if (state != IDLE && cycle_count != 16'hFFFF)
                cycle_count <= cycle_count + 16'd1;
            case (state)
                FETCH: if (fetch_pc == len) state <= DRAIN;
                DRAIN: begin
                    if (count == '0) begin
                        state      <= DONE;
                        fetch_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IFQ_STALL_CNT_EN
    // Counts FETCH cycles where the queue is full and nothing can be written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (start)
            stall_count <= '0;
        else if (state == FETCH && count == CW'(DEPTH) && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif

    assign inst0_valid = (count != '0);
    assign inst1_valid = (count >= CW'(2));
    assign inst0       = inst0_valid ? queue_mem[head] : '0;
    assign inst1       = inst1_valid ? queue_mem[head + PW'(1)] : '0;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue: a queue-level reference model
// predicts per-cycle outputs; a negedge monitor compares them.
module tb_instruction_fetch_queue;

    localparam int DEPTH = 8;
    localparam int P_IDLE = 0, P_FETCH = 1, P_DRAIN = 2, P_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic [7:0]  prog_len = '0;
    logic        start = 1'b0;
    logic [1:0]  issue_take = '0;
    logic [31:0] inst0, inst1;
    logic        inst0_valid, inst1_valid, fetch_done;
    logic [3:0]  count;
    logic [15:0] cycle_count;
`ifdef IFQ_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    instruction_fetch_queue #(.DEPTH(DEPTH), .PC_W(8), .INST_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_len(prog_len), .start(start), .issue_take(issue_take),
        .inst0(inst0), .inst0_valid(inst0_valid),
        .inst1(inst1), .inst1_valid(inst1_valid),
        .count(count), .fetch_done(fetch_done), .cycle_count(cycle_count)
`ifdef IFQ_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int          cnt;
        logic [31:0] i0;
        logic [31:0] i1;
        bit          v0;
        bit          v1;
        bit          done;
        int          cyc;
        int          stall;
    } snap_t;

    snap_t       exp_q [$];
    logic [31:0] m_mem [256];
    logic [31:0] m_q [$];
    int m_pc, m_len, m_phase, m_cyc, m_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int min3(input int a, input int b, input int c);
        int m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc = 0; m_len = 0; m_phase = P_IDLE; m_cyc = 0; m_stall = 0;
    endtask

    // One clock of the reference: fetch reads memory before this edge's write lands.
    task automatic model_step(input bit st, input int take, input bit we,
                              input int wa, input logic [31:0] wd, input int plen);
        if (st) begin
            m_q.delete();
            m_pc = 0; m_len = plen; m_phase = P_FETCH; m_cyc = 0; m_stall = 0;
        end else begin
            int c = m_q.size();
            int t = (take > c) ? c : take;
            int n = 0;
            logic [31:0] w [2];
            if (m_phase == P_FETCH) n = min3(2, DEPTH - c, m_len - m_pc);
            for (int i = 0; i < n; i++) w[i] = m_mem[(m_pc + i) % 256];
            if (m_phase == P_FETCH && c == DEPTH && m_stall < 65535) m_stall++;
            if (m_phase != P_IDLE && m_cyc < 65535) m_cyc++;
            if (m_phase == P_FETCH && m_pc == m_len) m_phase = P_DRAIN;
            else if (m_phase == P_DRAIN && c == 0) m_phase = P_DONE;
            for (int i = 0; i < t; i++) void'(m_q.pop_front());
            for (int i = 0; i < n; i++) m_q.push_back(w[i]);
            m_pc += n;
        end
        if (we) m_mem[wa] = wd;
    endtask

    task automatic push_snap();
        snap_t s;
        s.cnt   = m_q.size();
        s.v0    = (m_q.size() >= 1);
        s.v1    = (m_q.size() >= 2);
        s.i0    = s.v0 ? m_q[0] : 32'h0;
        s.i1    = s.v1 ? m_q[1] : 32'h0;
        s.done  = (m_phase == P_DONE);
        s.cyc   = m_cyc;
        s.stall = m_stall;
        exp_q.push_back(s);
    endtask

    task automatic cycle(input bit st, input int take);
        start      = st;
        issue_take = take[1:0];
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(st, take, prog_we, int'(prog_addr), prog_data, int'(prog_len));
        push_snap();
        #1;
        start = 1'b0; issue_take = '0; prog_we = 1'b0;
    endtask

    task automatic write_word(input int addr, input logic [31:0] data);
        prog_addr = addr[7:0]; prog_data = data; prog_we = 1'b1;
        cycle(1'b0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},  count, 0);
        check({tag, "_v0"},     inst0_valid, 0);
        check({tag, "_v1"},     inst1_valid, 0);
        check({tag, "_inst0"},  inst0, 0);
        check({tag, "_inst1"},  inst1, 0);
        check({tag, "_done"},   fetch_done, 0);
        check({tag, "_cycles"}, cycle_count, 0);
    endtask

    // Monitor: compares the DUT against the next predicted snapshot mid-cycle.
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check("count",       count, s.cnt);
                check("inst0_valid", inst0_valid, s.v0);
                check("inst1_valid", inst1_valid, s.v1);
                check("inst0",       inst0, s.i0);
                check("inst1",       inst1, s.i1);
                check("fetch_done",  fetch_done, s.done);
                check("cycle_count", cycle_count, s.cyc);
`ifdef IFQ_STALL_CNT_EN
                check("stall_count", stall_count, s.stall);
`endif
            end
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) write_word(i, $urandom);

        // Six words, no consumption: 2, 4, 6 then hold without reaching DONE.
        prog_len = 8'd6;
        cycle(1'b1, 0);
        repeat (8) cycle(1'b0, 0);

        // Same program drained in pairs.
        cycle(1'b1, 0);
        repeat (10) cycle(1'b0, (m_q.size() >= 2) ? 2 : 0);

        // Twenty words: fill to full, stall, then single takes through wrap.
        prog_len = 8'd20;
        cycle(1'b1, 0);
        repeat (14) cycle(1'b0, 0);
        repeat (30) cycle(1'b0, 1);

        // Over-take with a single entry must not underflow.
        prog_len = 8'd1;
        cycle(1'b1, 0);
        cycle(1'b0, 0);
        repeat (2) cycle(1'b0, 2);
        repeat (3) cycle(1'b0, 0);

        // Asynchronous reset mid-FETCH with five entries queued, then replay.
        prog_len = 8'd20;
        cycle(1'b1, 0);
        cycle(1'b0, 0);
        cycle(1'b0, 0);
        cycle(1'b0, 1);
        check("pre_reset_count", count, 5);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        cycle(1'b0, 0);
        rst_n = 1'b1;
        repeat (2) cycle(1'b0, 1);
        cycle(1'b1, 0);
        repeat (12) cycle(1'b0, $urandom_range(0, 2));

        // Restart while draining with three entries.
        prog_len = 8'd3;
        cycle(1'b1, 0);
        repeat (3) cycle(1'b0, 0);
        cycle(1'b1, 0);
        repeat (4) cycle(1'b0, 0);

        // Empty program: FETCH, then DRAIN, then DONE.
        prog_len = 8'd0;
        cycle(1'b1, 0);
        repeat (3) cycle(1'b0, 0);

        // Random restarts, takes and program rewrites (including live addresses).
        repeat (600) begin
            bit st = ($urandom_range(0, 39) == 0);
            if (st) prog_len = 8'($urandom_range(0, 40));
            if ($urandom_range(0, 9) == 0) begin
                prog_addr = 8'($urandom_range(0, 63));
                prog_data = $urandom;
                prog_we   = 1'b1;
            end
            cycle(st, $urandom_range(0, 2));
        end

        repeat (3) cycle(1'b0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
